// File: rtl/instr_pkg.sv
// Shared instruction-set definitions for the issue encoder and the decoder.
// Holds opcode widths, fixed opcodes and the one-hot encode helpers.
package instr_pkg;

  localparam int unsigned NUM_OPS = 16;
  localparam int unsigned INSTR_W = 8;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [NUM_OPS-1:0] op_onehot_t;

  localparam instr_t OPC_NOP = 8'h00;
  localparam instr_t OPC_NOT = 8'h0F;

  function automatic logic is_onehot(op_onehot_t r);
    return (r != '0) && ((r & (r - op_onehot_t'(1))) == '0);
  endfunction

  // Anything that is not exactly one-hot falls back to NOP, like the decoder.
  function automatic instr_t encode_onehot(op_onehot_t r);
    instr_t b;
    b = OPC_NOP;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (r == (op_onehot_t'(1) << i)) b = instr_t'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/instruction_issue_encoder_if.sv
// Request and instruction-issue streams of the issue encoder.
// master = sequencer/consumer side, slave = the encoder.
interface instruction_issue_encoder_if;
  import instr_pkg::*;

  op_onehot_t req;
  logic       req_valid;
  logic       req_ready;
  instr_t     instr;
  logic       instr_valid;
  logic       instr_ready;

  modport master (
    output req, req_valid, instr_ready,
    input  req_ready, instr, instr_valid
  );

  modport slave (
    input  req, req_valid, instr_ready,
    output req_ready, instr, instr_valid
  );
endinterface

// File: rtl/instr_fifo.sv
// Power-of-two FIFO for encoded instruction bytes with synchronous flush.
// Read data is forced to zero while empty so no stale storage leaks out.
module instr_fifo
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = INSTR_W,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem[rd_q];

  // Flush wins over both sides; a full FIFO refuses a push even while popping.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/instruction_issue_encoder.sv
// Encodes one-hot operation requests into instruction bytes and issues them
// through a FIFO; malformed requests issue as NOP and are flagged and counted.
module instruction_issue_encoder
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  instruction_issue_encoder_if.slave  bus,
  output logic                        illegal,
  output logic [CNTW-1:0]             illegal_cnt,
  output logic [CW-1:0]               count
);

  logic   full, empty, accept, malformed;
  instr_t enc;
  logic   illegal_q, illegal_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign enc       = encode_onehot(bus.req);
  assign malformed = !is_onehot(bus.req);

  assign bus.req_ready   = !full;
  assign bus.instr_valid = !empty;
  assign accept          = bus.req_valid && !full && !flush;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.req_valid),
    .wdata   (enc),
    .pop     (bus.instr_ready),
    .flush   (flush),
    .rdata   (bus.instr),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    illegal_d = accept && malformed;
    cnt_d     = cnt_q;
    if (illegal_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_issue_encoder.sv
// Directed, table-driven bench for instruction_issue_encoder (DEPTH=4, CNTW=8).
module tb_instruction_issue_encoder;
  import instr_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic            illegal;
  logic [CNTW-1:0] illegal_cnt;
  logic [CW-1:0]   count;

  instruction_issue_encoder_if bus ();

  instruction_issue_encoder #(
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .bus         (bus),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_onehot_t req;
    instr_t     exp_instr;
    logic       exp_ill;
  } vec_t;

  vec_t vecs [20];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bus.req         = '0;
    bus.req_valid   = 1'b0;
    bus.instr_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vecs[i].req       = op_onehot_t'(1) << i;
      vecs[i].exp_instr = instr_t'(i);
      vecs[i].exp_ill   = 1'b0;
    end
    vecs[16] = '{req: 16'h0000, exp_instr: 8'h00, exp_ill: 1'b1};
    vecs[17] = '{req: 16'h0011, exp_instr: 8'h00, exp_ill: 1'b1};
    vecs[18] = '{req: 16'hFFFF, exp_instr: 8'h00, exp_ill: 1'b1};
    vecs[19] = '{req: 16'h8001, exp_instr: 8'h00, exp_ill: 1'b1};

    // Reset state
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_instr", 32'(bus.instr), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_cnt", 32'(illegal_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single pushes from the table, each drained before the next
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.req = vecs[i].req;
      bus.req_valid = 1'b1;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (vecs[i].exp_ill) exp_cnt++;
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 1);
      check($sformatf("vec%0d_instr", i), 32'(bus.instr), 32'(vecs[i].exp_instr));
      check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].exp_ill));
      check($sformatf("vec%0d_cnt", i), 32'(illegal_cnt), 32'(exp_cnt));
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      check($sformatf("vec%0d_drain", i), 32'(count), 0);
      check($sformatf("vec%0d_ill_off", i), 32'(illegal), 0);
    end

    // Back-to-back sweep with consumer always ready
    @(negedge clk);
    bus.instr_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req = 16'h0001;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("sweep%0d_instr", k), 32'(bus.instr), 32'(k - 1));
      check($sformatf("sweep%0d_count", k), 32'(count), 1);
      if (k < 16) bus.req = op_onehot_t'(1) << k;
      else bus.req_valid = 1'b0;
    end
    @(negedge clk);
    check("sweep_empty", 32'(count), 0);
    check("sweep_valid", 32'(bus.instr_valid), 0);

    // Fill to full with consumer stalled, fifth request held off
    bus.instr_ready = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req = op_onehot_t'(1) << (3 + i);
      check($sformatf("full_ready%0d", i), 32'(bus.req_ready), (i < 4) ? 1 : 0);
      @(negedge clk);
    end
    check("full_count", 32'(count), 4);
    check("full_ready_low", 32'(bus.req_ready), 0);
    check("full_head", 32'(bus.instr), 3);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("full_pop_only", 32'(count), 3);
    check("full_head2", 32'(bus.instr), 4);
    check("full_ready_back", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("full_pushpop", 32'(count), 3);
    check("full_head3", 32'(bus.instr), 5);
    @(negedge clk);
    check("full_head4", 32'(bus.instr), 6);
    @(negedge clk);
    check("full_head5", 32'(bus.instr), 7);
    check("full_count1", 32'(count), 1);
    @(negedge clk);
    check("full_drained", 32'(count), 0);

    // Fill 3 (last malformed), then flush with push and pop requested
    bus.instr_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req = 16'h0002;
    @(negedge clk);
    bus.req = 16'h0200;
    @(negedge clk);
    bus.req = 16'h0003;
    @(negedge clk);
    exp_cnt++;
    check("pre_flush_count", 32'(count), 3);
    check("pre_flush_illegal", 32'(illegal), 1);
    bus.req = 16'h0000;
    bus.instr_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.instr_ready = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(bus.instr_valid), 0);
    check("flush_instr", 32'(bus.instr), 0);
    check("flush_illegal", 32'(illegal), 0);
    check("flush_cnt", 32'(illegal_cnt), 32'(exp_cnt));

    // Saturation of the illegal counter
    bus.instr_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req = 16'h0101;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_cnt < 255) exp_cnt++;
    end
    check("sat_cnt", 32'(illegal_cnt), 32'(exp_cnt));
    check("sat_illegal", 32'(illegal), 1);

    // Asynchronous reset mid-stream
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(bus.instr_valid), 0);
    check("arst_instr", 32'(bus.instr), 0);
    check("arst_illegal", 32'(illegal), 0);
    check("arst_cnt", 32'(illegal_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.req = 16'h0400;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("post_rst_instr", 32'(bus.instr), 32'h0A);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_illegal", 32'(illegal), 0);
    check("post_rst_cnt", 32'(illegal_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_issue_encoder.md
Name: instruction_issue_encoder

Overview:
- Inverse of the instruction decoder: takes a 16-bit one-hot operation request (bit 0 = NOP, bit 15 = NOT) and encodes it to the 8-bit instruction byte {4'b0000, index}.
- Encoded bytes are buffered in a small FIFO and issued downstream over a valid/ready handshake.
- Malformed requests (zero or multiple bits set) issue as NOP, matching decoder fallback, and are counted.
- Sits between the control/test sequencer and the instruction input of the datapath.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
CNTW, 8, width of saturating illegal-request counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  16  one-hot operation request; bit i selects opcode i
req_valid  input  1  req is valid this cycle
req_ready  output  1  block can accept a request this cycle
flush  input  1  synchronous clear of FIFO contents
instr  output  8  instruction byte at FIFO head
instr_valid  output  1  instr is valid
instr_ready  input  1  consumer takes instr this cycle
illegal  output  1  one-cycle pulse: previously accepted request was malformed
illegal_cnt  output  CNTW  saturating count of malformed requests
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset_n low, async): pointers, count, illegal, illegal_cnt all 0; instr_valid 0; instr reads 8'h00; storage contents don't care.
- Encoding (combinational on req):
  - exactly one bit i set -> 8'h0i;
  - zero bits or >1 bit set -> 8'h00 (NOP), marked illegal.
  - Upper nibble of an encoded byte is always 4'b0000.
- Push: req_valid && req_ready at a rising edge writes the encoded byte at the write pointer.
  - req_ready = (count != DEPTH), purely from state; it does not depend on instr_ready in the same cycle.
  - When full, a push is refused even if a pop occurs that cycle.
- Pop: instr_valid && instr_ready at an edge advances the read pointer.
  - instr_valid = (count != 0); instr = mem[rd_ptr], so the output is registered storage with no combinational path from req.
- Latency: a request accepted at edge N is visible with instr_valid=1 in the cycle after edge N, provided the FIFO was empty. Order is strictly FIFO.
- Simultaneous push and pop while not full and not empty: both occur; count unchanged.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- illegal:
  - registered; high for exactly the one cycle after the edge that accepted a malformed request, otherwise 0;
  - not asserted for req_valid without acceptance.
- illegal_cnt: increments on each accepted malformed request; saturates at 2^CNTW-1; cleared only by reset.
- flush:
  - at an edge, sets pointers and count to 0 and overrides any push or pop in the same cycle (the request is not accepted, so illegal is not raised);
  - illegal_cnt is unaffected;
  - an illegal pulse already pending from the previous edge still deasserts normally.
- Reset asserted mid-operation discards FIFO contents immediately; after reset release, the first accept behaves as from empty.
- No X propagation: instr is driven from storage only when instr_valid=1, otherwise 8'h00.

Decomposition:
- Shared package instr_pkg:
  - NUM_OPS = 16;
  - INSTR_W = 8;
  - OPC_NOP = 8'h00, OPC_NOT = 8'h0F;
  - typedef logic [INSTR_W-1:0] instr_t;
  - typedef logic [NUM_OPS-1:0] op_onehot_t.
- The decoder is to be migrated onto the same package.
- Sub-module instr_fifo (parameterised DEPTH, width INSTR_W; push/pop/flush/count) holds all storage and pointer logic.
- Top-level logic is limited to the one-hot encode/legality check, the illegal pulse and the counter.

Test Plan:
- Reset then single push req=16'h0001 -> instr=8'h00, instr_valid=1 in the next cycle, illegal=0; req=16'h8000 -> 8'h0F.
- Sweep all 16 one-hot values back-to-back with instr_ready=1 -> bytes 8'h00..8'h0F issued in order, one per cycle after first, count never exceeds 1.
- req=16'h0000 then req=16'h0011 -> both issue 8'h00, illegal pulses on each of the two cycles following acceptance, illegal_cnt=2.
- instr_ready=0, push 5 requests with DEPTH=4 -> req_ready drops after 4th accept, count=4, 5th held off; then instr_ready=1 with req_valid held -> pop and refused push alternate correctly, order preserved, no loss.
- Fill 3 entries, assert flush with req_valid=1 and instr_ready=1 -> next cycle count=0, instr_valid=0, flushed request not accepted, illegal_cnt unchanged.
- Force 300 malformed accepts (CNTW=8) -> illegal_cnt saturates at 255; assert reset_n low mid-stream -> all outputs 0 asynchronously, before the next clock edge.
